// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the FPU blocks: field layout, bias and
// the sequencing states of the divider.
package fp_pkg;

  localparam int          FP_EXP_W = 8;
  localparam int          FP_MAN_W = 23;
  localparam logic [7:0]  FP_BIAS  = 8'd127;
  localparam logic [31:0] FP_QNAN  = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] frac;
  } fp_t;

endpackage

// File: rtl/floating_division_core.sv
// Restoring mantissa divider: q = floor(Ma * 2^24 / Mb), one quotient bit
// per clock, MSB first, 25 iterations after start.
module floating_division_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] Ma,
  input  logic [23:0] Mb,
  output logic [24:0] q,
  output logic        done
);

  logic [24:0] rem;
  logic [23:0] mb_r;
  logic [4:0]  cnt;
  logic [25:0] diff;
  logic        ge;
  logic [24:0] rem_next;

  assign diff     = {1'b0, rem} - {2'b00, mb_r};
  assign ge       = ~diff[25];
  assign rem_next = ge ? diff[24:0] : rem;

  // High while the final iteration is in flight; q is complete after that edge.
  assign done = (cnt == 5'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      mb_r <= '0;
      q    <= '0;
      cnt  <= '0;
    end else if (start) begin
      rem  <= {1'b0, Ma};
      mb_r <= Mb;
      q    <= '0;
      cnt  <= 5'd25;
    end else if (cnt != 5'd0) begin
      rem  <= rem_next << 1;
      q    <= {q[23:0], ge};
      cnt  <= cnt - 5'd1;
    end
  end

endmodule

// File: rtl/floating_division.sv
// Sequential binary32 divider with valid/ready on both sides; truncating,
// 8-bit wrapping exponent. FDIV_SPECIAL_EN adds zero/inf/NaN handling.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// DIV   | mantissa divider iterating (25 cycles)
// NORM  | normalise quotient, register result
// DONE  | out_valid held until out_ready
module floating_division
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  fp_t         a_f, b_f;
  state_t      state;
  logic        sign_r;
  logic [7:0]  ea_r, eb_r;
  logic        accept;
  logic        core_start;
  logic        core_done;
  logic [24:0] q;
  logic [22:0] mant;
  logic [31:0] norm_res;

  assign a_f    = A;
  assign b_f    = B;
  assign accept = in_valid && in_ready;
  assign mant   = q[24] ? q[23:1] : q[22:0];

`ifdef FDIV_SPECIAL_EN
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, op_sign;
  logic              is_special, special_r;
  logic [31:0]       special_res, special_res_r;
  logic signed [9:0] exp_w;

  assign a_nan   = (&a_f.exp) && (|a_f.frac);
  assign b_nan   = (&b_f.exp) && (|b_f.frac);
  assign a_inf   = (&a_f.exp) && !(|a_f.frac);
  assign b_inf   = (&b_f.exp) && !(|b_f.frac);
  assign a_zero  = (a_f.exp == 8'd0);
  assign b_zero  = (b_f.exp == 8'd0);
  assign op_sign = a_f.sign ^ b_f.sign;

  always_comb begin
    is_special  = 1'b1;
    special_res = FP_QNAN;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      special_res = FP_QNAN;
    else if (b_zero || a_inf)
      special_res = {op_sign, 8'hFF, 23'd0};
    else if (a_zero || b_inf)
      special_res = {op_sign, 31'd0};
    else
      is_special = 1'b0;
  end

  assign core_start = accept && !is_special;
  assign exp_w = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r})
               + (q[24] ? 10'sd127 : 10'sd126);

  always_comb begin
    if (special_r)
      norm_res = special_res_r;
    else if (exp_w > 10'sd254)
      norm_res = {sign_r, 8'hFF, 23'd0};
    else if (exp_w < 10'sd1)
      norm_res = {sign_r, 31'd0};
    else
      norm_res = {sign_r, exp_w[7:0], mant};
  end
`else
  logic [7:0] exp_n;

  assign core_start = accept;
  assign exp_n      = ea_r - eb_r + (q[24] ? FP_BIAS : FP_BIAS - 8'd1);
  assign norm_res   = {sign_r, exp_n, mant};
`endif

  floating_division_core u_core (
    .clk   (clk),
    .rst   (rst),
    .start (core_start),
    .Ma    ({1'b1, a_f.frac}),
    .Mb    ({1'b1, b_f.frac}),
    .q     (q),
    .done  (core_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      sign_r    <= 1'b0;
      ea_r      <= '0;
      eb_r      <= '0;
`ifdef FDIV_SPECIAL_EN
      special_r     <= 1'b0;
      special_res_r <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_r   <= a_f.sign ^ b_f.sign;
            ea_r     <= a_f.exp;
            eb_r     <= b_f.exp;
            in_ready <= 1'b0;
            state    <= DIV;
`ifdef FDIV_SPECIAL_EN
            special_r     <= is_special;
            special_res_r <= special_res;
            // Special operands bypass the divider and resolve on the next edge.
            if (is_special) state <= NORM;
`endif
          end
        end
        DIV: begin
          if (core_done) state <= NORM;
        end
        NORM: begin
          result    <= norm_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_floating_division.sv
// Self-checking bench for floating_division: directed vector table, handshake
// and reset corner sequences, and random operands against a reference model.
module tb_floating_division;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] A, B, result;
  logic        out_valid, out_ready;

  int passed = 0;
  int total  = 0;

  floating_division dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  // Quotient from exact integer division of the significands, then the
  // binade choice and biased exponent taken modulo 256.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, qq;
    int              e;
    logic [22:0]     m;
    ma = 64'({1'b1, a[22:0]});
    mb = 64'({1'b1, b[22:0]});
    qq = (ma << 24) / mb;
    e  = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (qq >= (64'd1 << 24)) begin
      m = 23'((qq >> 1) & 64'h7FFFFF);
    end else begin
      m = 23'(qq & 64'h7FFFFF);
      e = e - 1;
    end
    return {a[31] ^ b[31], 8'(e), m};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic accept_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    start_op(a, b);
    wait_valid(lat);
    res = result;
    accept_result();
  endtask

  vec_t        vecs[7];
  logic [31:0] res, held, ra, rb;
  int          lat;
  bit          seen;

  initial begin
    vecs[0] = '{"six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 26};
    vecs[1] = '{"one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26};
    vecs[2] = '{"neg8_by_half", 32'hC1000000, 32'h3F000000, 32'hC1800000, 26};
    vecs[3] = '{"one_by_one",   32'h3F800000, 32'h3F800000, 32'h3F800000, 26};
    vecs[4] = '{"three_by_two", 32'h40400000, 32'h40000000, 32'h3FC00000, 26};
    vecs[5] = '{"one_by_neg4",  32'h3F800000, 32'hC0800000, 32'hBE800000, 26};
`ifdef FDIV_SPECIAL_EN
    vecs[6] = '{"one_by_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 1};
`else
    vecs[6] = '{"one_by_zero",  32'h3F800000, 32'h00000000, 32'h7F000000, 26};
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    #12;
    check32("rst_in_ready",  32'(in_ready),  32'd1);
    check32("rst_out_valid", 32'(out_valid), 32'd0);
    check32("rst_result",    result,         32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, res, lat);
      check32({vecs[i].name, "_res"}, res, vecs[i].exp);
      check32({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      check32({vecs[i].name, "_in_ready_after"}, 32'(in_ready), 32'd1);
    end

    // Backpressure: hold out_ready low, poke in_valid, then release.
    start_op(32'h40C00000, 32'h40000000);
    wait_valid(lat);
    held = result;
    check32("bp_first_result", held, 32'h40400000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        in_valid = 1'b1;
        A = 32'h3F800000;
        B = 32'h40400000;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check32("bp_result_stable", result, held);
      check32("bp_in_ready_low", 32'(in_ready), 32'd0);
      check32("bp_out_valid_held", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check32("bp_in_ready_next", 32'(in_ready), 32'd1);
    check32("bp_out_valid_drop", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check32("bp_pulse_ignored", 32'(seen), 32'd0);

    // Reset in the middle of the divide.
    start_op(32'h3F800000, 32'h40400000);
    check32("busy_in_ready", 32'(in_ready), 32'd0);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check32("abort_in_ready",  32'(in_ready),  32'd1);
    check32("abort_out_valid", 32'(out_valid), 32'd0);
    check32("abort_result",    result,         32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check32("abort_no_valid", 32'(seen), 32'd0);
    run_op(32'hC1000000, 32'h3F000000, res, lat);
    check32("after_abort_res", res, 32'hC1800000);
    check32("after_abort_lat", 32'(lat), 32'd26);

    // Random operands kept in a range that stays normal in either build.
    for (int i = 0; i < 20; i++) begin
      ra = {1'($urandom), 8'($urandom_range(184, 70)), 23'($urandom)};
      rb = {1'($urandom), 8'($urandom_range(184, 70)), 23'($urandom)};
      run_op(ra, rb, res, lat);
      check32("rand_res", res, ref_div(ra, rb));
      check32("rand_lat", 32'(lat), 32'd26);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
